// File: rtl/rv_muldiv_unit_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - funct3 encodings for the RV32M/RV64M operations
//   - FSM state encoding
//   - helpers telling which operands are treated as signed
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } state_t;

    // rs1 is signed for MULH, MULHSU, DIV, REM
    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is signed for MULH, DIV, REM
    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/rv_muldiv_unit_if.sv
// rv_muldiv_unit_if: request/response bundle between the execute stage
// (master) and the multiply/divide unit (slave).
//   start/funct3/op_a/op_b : operation launch
//   flush                  : abort in-flight operation
//   busy                   : stall request to IF/ID/EX registers
//   done/result            : one-cycle completion pulse and registered result
interface rv_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/rv_muldiv_unit_step.sv
// muldiv_step: one combinational 1-bit iteration on unsigned magnitudes.
//   is_div_i : 1 = restoring divide step, 0 = shift-add multiply step
//   hi_i/lo_i: multiply -> {partial product, remaining multiplier bits}
//              divide   -> {partial remainder, dividend/quotient shift reg}
//   opnd_i   : multiplicand (multiply) or divisor (divide)
//   hi_o/lo_o: state after this step
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            ge;

    // Multiply: add multiplicand when the next multiplier bit is set, then
    // shift the whole 2*XLEN accumulator right (carry lands in the top bit).
    assign sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    // Divide: shift the next dividend bit into the remainder. The remainder
    // is always below the divisor, so a successful subtract fits in XLEN bits.
    assign shifted = {hi_i, lo_i[XLEN-1]};
    assign ge      = shifted >= {1'b0, opnd_i};
    assign diff    = shifted[XLEN-1:0] - opnd_i;

    always_comb begin
        hi_o = '0;
        lo_o = '0;
        if (is_div_i) begin
            hi_o = ge ? diff : shifted[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], ge};
        end else begin
            {hi_o, lo_o} = {sum, lo_i[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: iterative RV32M/RV64M multiply/divide unit.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : rv_muldiv_unit_if slave (start/funct3/op_a/op_b/flush in,
//           busy/done/result out)
// Flow: IDLE latches operands, PREP takes magnitudes and handles divide
// special cases, CALC runs N iterations of BITS_PER_CYCLE steps, FIX
// applies the sign and selects the result.
module rv_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    rv_muldiv_unit_if.slave   bus
);
    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q, state_d;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] hi_q, lo_q, opnd_q, result_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_q, neg_rem_q, raw_q, done_q;

    // ---- PREP: lo_q holds raw op_a, opnd_q holds raw op_b ----
    logic            a_neg, b_neg, is_div, special;
    logic [XLEN-1:0] a_mag, b_mag, special_val;

    assign is_div  = f3_q[2];
    assign a_neg   = is_signed_a(f3_q) & lo_q[XLEN-1];
    assign b_neg   = is_signed_b(f3_q) & opnd_q[XLEN-1];
    assign a_mag   = a_neg ? -lo_q : lo_q;
    assign b_mag   = b_neg ? -opnd_q : opnd_q;

    always_comb begin
        special     = 1'b0;
        special_val = '0;
        if (is_div && opnd_q == '0) begin
            special     = 1'b1;
            special_val = f3_q[1] ? lo_q : '1;         // REM*: dividend, DIV*: all-ones
        end else if (is_div && is_signed_a(f3_q) && lo_q == MIN_NEG && opnd_q == '1) begin
            special     = 1'b1;
            special_val = f3_q[1] ? '0 : lo_q;         // signed overflow
        end
    end

    // ---- CALC: chain of single-bit steps ----
    logic [XLEN-1:0] chain_hi [BITS_PER_CYCLE+1];
    logic [XLEN-1:0] chain_lo [BITS_PER_CYCLE+1];

    assign chain_hi[0] = hi_q;
    assign chain_lo[0] = lo_q;

    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
            muldiv_step #(.XLEN(XLEN)) u_step (
                .is_div_i (is_div),
                .hi_i     (chain_hi[gi]),
                .lo_i     (chain_lo[gi]),
                .opnd_i   (opnd_q),
                .hi_o     (chain_hi[gi+1]),
                .lo_o     (chain_lo[gi+1])
            );
        end
    endgenerate

    // ---- FIX: sign correction and result selection ----
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_val;

    assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};

    always_comb begin
        fix_val = '0;
        if (raw_q) begin
            fix_val = lo_q;                            // special case value from PREP
        end else if (!is_div) begin
            fix_val = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (!f3_q[1]) begin
            fix_val = neg_q ? -lo_q : lo_q;            // quotient
        end else begin
            fix_val = neg_rem_q ? -hi_q : hi_q;        // remainder follows dividend sign
        end
    end

    // ---- FSM ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start && !bus.flush) state_d = PREP;
            PREP: state_d = bus.flush ? IDLE : (special ? FIX : CALC);
            CALC: if (bus.flush) state_d = IDLE;
                  else if (cnt_q == '0) state_d = FIX;
            FIX:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- Datapath ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f3_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            raw_q     <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start && !bus.flush) begin
                    f3_q   <= bus.funct3;
                    lo_q   <= bus.op_a;
                    opnd_q <= bus.op_b;
                    raw_q  <= 1'b0;
                end
                PREP: begin
                    hi_q      <= '0;
                    cnt_q     <= CW'(N - 1);
                    neg_q     <= a_neg ^ b_neg;
                    neg_rem_q <= a_neg;
                    if (special) begin
                        lo_q  <= special_val;
                        raw_q <= 1'b1;
                    end else if (is_div) begin
                        lo_q   <= a_mag;
                        opnd_q <= b_mag;
                    end else begin
                        lo_q   <= b_mag;               // multiplier bits shift out of lo
                        opnd_q <= a_mag;
                    end
                end
                CALC: begin
                    hi_q  <= chain_hi[BITS_PER_CYCLE];
                    lo_q  <= chain_lo[BITS_PER_CYCLE];
                    cnt_q <= cnt_q - 1'b1;
                end
                FIX: if (!bus.flush) begin
                    result_q <= fix_val;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state_q != IDLE) | (bus.start & ~bus.flush);
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: doc/rv_muldiv_unit.md
Name: rv_muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide unit that sits beside the ALU in the execute stage of the 5-stage pipeline.
- Accepts one operation per start pulse and asserts busy so the IF/ID/EX registers stall, as they already do for memory busywait.
- Width and radix are parametrised and produce an XLEN-bit result with RISC-V-exact corner semantics.
- A branch/jump flush aborts the operation in flight.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- BITS_PER_CYCLE, 1, bits retired per iteration (1, 2 or 4); must divide XLEN.
- N (localparam), XLEN/BITS_PER_CYCLE, iteration count.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  launch operation; sampled only in IDLE.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value (dividend / multiplicand).
- op_b  in  XLEN  rs2 value (divisor / multiplier).
- flush  in  1  abort; driven from branch_or_jump.
- busy  out  1  pipeline stall request; busy = (state != IDLE) | (start & ~flush).
- done  out  1  one-cycle pulse when result is valid.
- result  out  XLEN  registered result; holds until the next done.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, done=0, result=0, all internal registers cleared. busy=0 while start=0.
- States: IDLE, PREP, CALC, FIX.
- IDLE -> PREP: on start & ~flush. funct3, op_a and op_b are latched at this edge (cycle 0).
- PREP, 1 cycle:
  - Computes operand magnitudes and result sign.
  - Signed operands are MULH (both), MULHSU (op_a only), DIV/REM (both).
  - Loads counter = N-1.
  - Goes to FIX directly on a divide special case; otherwise goes to CALC.
- CALC, N cycles: each cycle performs BITS_PER_CYCLE steps.
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - Counter decrements; the last cycle is counter==0. CALC -> FIX.
- FIX, 1 cycle:
  - Applies two's-complement sign correction.
  - Selects the product low half (MUL) or high half (MULH*), or the quotient/remainder.
  - Writes result, pulses done at the next edge and returns to IDLE.
- Latency: done is high in cycle N+2 relative to the start edge (cycle 0). busy is high in cycles 0..N+1 and low in the done cycle.
- Divide special cases finish with done in cycle 2:
  - Divisor == 0: DIV/DIVU return all-ones; REM/REMU return op_a.
  - DIV/REM with op_a = -2^(XLEN-1) and op_b = -1: DIV returns op_a; REM returns 0.
- Division sign rules: quotient truncates toward zero; remainder takes the sign of the dividend.
- start while not IDLE: ignored.
- Back-to-back operation: start may be asserted in the done cycle because the state is IDLE there.
- flush in PREP/CALC/FIX: next state IDLE, no done, result unchanged, busy low the following cycle.
- flush & start together in IDLE: flush wins, nothing launches, busy=0.
- Asynchronous reset mid-operation: immediate IDLE with outputs at their reset values; no done afterward.
- Operands are used only as latched; op_a/op_b changes after cycle 0 have no effect.

Decomposition:
- Package muldiv_pkg:
  - funct3 localparams (F3_MUL .. F3_REMU);
  - state encoding (IDLE=2'd0, PREP=2'd1, CALC=2'd2, FIX=2'd3);
  - helper function is_signed_a/is_signed_b(funct3).
- One combinational sub-module muldiv_step performs a single 1-bit multiply/divide step. It is instantiated BITS_PER_CYCLE times in a chain inside CALC.

Test Plan:
- XLEN=32, BITS_PER_CYCLE=1. MUL 7 × 0xFFFFFFFD (-3) -> result 0xFFFFFFEB. done in cycle 34 only; busy high cycles 0..33.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM 0xFFFFFFF9%2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100%7 -> 2.
  - Rerun with BITS_PER_CYCLE=4: identical results, done in cycle 10.
- Special cases: DIV 5/0 -> 0xFFFFFFFF; REM 5%0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
  - All four report done in cycle 2.
- DIVU started, flush in cycle 10 -> no done, busy=0 from cycle 11, result keeps its previous value.
  - start+flush together in IDLE -> busy=0, no launch.
- reset=0 in cycle 5 of a MUL -> result=0, done=0, busy=0 immediately.
  - After release, MUL 3×4 -> 12 with normal latency.
  - A second start in the done cycle is accepted back-to-back.
